// File: rtl/sram_like_ram_slave_if.sv
// Sram-like data-side bus: request fields from the master, accept/response strobes back.
interface sram_like_ram_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_ram_slave.sv
// Sram-like responder backed by a word-organised RAM, with configurable accept/data latency
// and an in-order queue of outstanding responses.
module sram_like_ram_slave #(
  parameter int    ADDR_WIDTH      = 12,
  parameter int    ADDR_LAT        = 0,
  parameter int    DATA_LAT        = 1,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string INIT_FILE       = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  sram_like_ram_slave_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMR_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;

  typedef struct packed {
    logic             is_read;
    logic [31:0]      data;
    logic [TMR_W-1:0] timer;
  } entry_t;

  logic [31:0]           mem [DEPTH];
  entry_t                queue [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            byte_en;
  logic                  lat_ok, accept, retire;

  // Upper address bits alias onto the RAM and are deliberately ignored.
  wire unused_addr = &{1'b0, bus.addr[31:ADDR_WIDTH+2]};

  assign idx    = bus.addr[ADDR_WIDTH+1:2];
  assign accept = bus.req & bus.addr_ok;
  assign retire = (count != '0) && (queue[head].timer == '0);

  assign bus.addr_ok = bus.req & ~stall & ~rst & (count < CNT_W'(MAX_OUTSTANDING)) & lat_ok;
  assign bus.data_ok = retire;
  assign bus.rdata   = (retire && queue[head].is_read) ? queue[head].data : 32'h0;

  // Address-phase wait counter only exists when an accept delay is configured.
  if (ADDR_LAT == 0) begin : g_no_wait
    assign lat_ok = 1'b1;
  end else begin : g_wait
    localparam int WCNT_W = $clog2(ADDR_LAT + 1);
    logic [WCNT_W-1:0] wcnt;

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
      if (rst || !bus.req || accept) wcnt <= '0;
      else if (wcnt != WCNT_W'(ADDR_LAT)) wcnt <= wcnt + 1'b1;
    end

    assign lat_ok = (wcnt == WCNT_W'(ADDR_LAT));
  end

  always_comb begin
    // NOTE: a default is assigned first so no path through the case can infer a latch.
    byte_en = 4'b1111;
    unique case (bus.size)
      2'b00:   byte_en = 4'b0001 << bus.addr[1:0];
      2'b01:   byte_en = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the RAM is never reset; its contents must survive rst, and a reset term
  // would also prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= ptr_next(tail);
      if (retire) head <= ptr_next(head);
      count <= count + CNT_W'(accept) - CNT_W'(retire);
    end
  end

  // Reads capture the RAM word before this edge's write port updates it, so
  // earlier writes are visible and later ones are not.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (accept && tail == PTR_W'(i)) begin
        queue[i] <= '{is_read: !bus.wr, data: mem[idx], timer: TMR_W'(DATA_LAT - 1)};
      end else if (queue[i].timer != '0) begin
        queue[i].timer <= queue[i].timer - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.req && !bus.addr_ok) |=> (bus.req && $stable({bus.wr, bus.size, bus.addr, bus.wdata})));
`endif

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Directed bench: three responder instances (default, slow accept, deep latency) share one
// request driver selected by sel; expected values are hand-computed constants.
module tb_sram_like_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  sel;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  sram_like_ram_slave_if if_a ();
  sram_like_ram_slave_if if_b ();
  sram_like_ram_slave_if if_c ();

  assign if_a.req = req && (sel == 2'd0);
  assign if_b.req = req && (sel == 2'd1);
  assign if_c.req = req && (sel == 2'd2);
  assign {if_a.wr, if_a.size, if_a.addr, if_a.wdata} = {wr, size, addr, wdata};
  assign {if_b.wr, if_b.size, if_b.addr, if_b.wdata} = {wr, size, addr, wdata};
  assign {if_c.wr, if_c.size, if_c.addr, if_c.wdata} = {wr, size, addr, wdata};

  always_comb begin
    addr_ok = if_a.addr_ok;
    data_ok = if_a.data_ok;
    rdata   = if_a.rdata;
    if (sel == 2'd1) begin
      addr_ok = if_b.addr_ok; data_ok = if_b.data_ok; rdata = if_b.rdata;
    end else if (sel == 2'd2) begin
      addr_ok = if_c.addr_ok; data_ok = if_c.data_ok; rdata = if_c.rdata;
    end
  end

  sram_like_ram_slave u_a (.clk(clk), .rst(rst), .stall(stall), .bus(if_a));
  sram_like_ram_slave #(.ADDR_LAT(3), .DATA_LAT(4)) u_b (.clk(clk), .rst(rst), .stall(stall), .bus(if_b));
  sram_like_ram_slave #(.DATA_LAT(5), .MAX_OUTSTANDING(2)) u_c (.clk(clk), .rst(rst), .stall(stall), .bus(if_c));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request and holds it until accepted; waits = extra cycles before addr_ok.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        output int waits);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    waits = 0;
    @(negedge clk);
    while (!addr_ok && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Waits for the next data_ok; lat = cycles after the handshake cycle.
  task automatic do_resp(output logic [31:0] d, output int lat);
    lat = 1;
    @(negedge clk);
    while (!data_ok && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = data_ok ? rdata : 32'hDEAD_DEAD;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input int exp_wait, input int exp_lat, input logic [31:0] exp_data);
    int waits, lat;
    logic [31:0] got;
    do_req(w, sz, a, d, waits);
    check({tag, "_wait"}, waits, exp_wait);
    do_resp(got, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, got, exp_data);
  endtask

  initial begin
    int seen, nd, acc3, ndok;
    int          dcyc [3];
    logic [31:0] ddat [3];

    // Test 1: reset with a request already pending on the default instance.
    rst = 1'b1; stall = 1'b0; sel = 2'd0;
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", addr_ok, 1'b0);
    check("rst_data_ok", data_ok, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer("t1_wr", 1'b1, 2'b10, 32'h10, 32'h1234_5678, 0, 1, 32'h0);
    xfer("t1_rd", 1'b0, 2'b10, 32'h10, 32'h0, 0, 1, 32'h1234_5678);

    // Test 2: byte/half lane enables, including size 11 as word and ignored addr[0].
    xfer("t2_zero", 1'b1, 2'b10, 32'h04, 32'h0, 0, 1, 32'h0);
    xfer("t2_byte", 1'b1, 2'b00, 32'h12, 32'h00AB_0000, 0, 1, 32'h0);
    xfer("t2_half", 1'b1, 2'b01, 32'h06, 32'hBEEF_0000, 0, 1, 32'h0);
    xfer("t2_rd10", 1'b0, 2'b10, 32'h10, 32'h0, 0, 1, 32'h12AB_5678);
    xfer("t2_rd04", 1'b0, 2'b10, 32'h04, 32'h0, 0, 1, 32'hBEEF_0000);
    xfer("t2_b3", 1'b1, 2'b00, 32'h13, 32'h9900_0000, 0, 1, 32'h0);
    xfer("t2_h0", 1'b1, 2'b01, 32'h05, 32'h0000_1234, 0, 1, 32'h0);
    xfer("t2_sz3", 1'b1, 2'b11, 32'h08, 32'hCAFE_F00D, 0, 1, 32'h0);
    xfer("t2_rd10b", 1'b0, 2'b10, 32'h10, 32'h0, 0, 1, 32'h99AB_5678);
    xfer("t2_rd04b", 1'b0, 2'b01, 32'h04, 32'h0, 0, 1, 32'hBEEF_1234);
    xfer("t2_rd08", 1'b0, 2'b00, 32'h08, 32'h0, 0, 1, 32'hCAFE_F00D);

    // Test 5: read issued the cycle after a write to the same word.
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h1;
    @(negedge clk);
    check("t5_wr_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    wr = 1'b0; wdata = 32'h0;
    @(negedge clk);
    check("t5_rd_aok", addr_ok, 1'b1);
    check("t5_wr_dok", data_ok, 1'b1);
    check("t5_wr_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("t5_rd_dok", data_ok, 1'b1);
    check("t5_rd_rdata", rdata, 32'h1);
    @(posedge clk); #1;

    // Test 3: ADDR_LAT=3, DATA_LAT=4, then stall holding off a saturated request.
    sel = 2'd1;
    xfer("t3_wr", 1'b1, 2'b10, 32'h0, 32'h55AA_55AA, 3, 4, 32'h0);
    stall = 1'b1;
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (addr_ok) seen++;
      @(posedge clk); #1;
    end
    check("t3_stall_blocks", seen, 0);
    stall = 1'b0;
    @(negedge clk);
    check("t3_unstall_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    begin
      int lat;
      logic [31:0] got;
      do_resp(got, lat);
      check("t3_rd_lat", lat, 4);
      check("t3_rd_rdata", got, 32'h55AA_55AA);
    end

    // Test 4: MAX_OUTSTANDING=2, DATA_LAT=5, three back-to-back reads.
    sel = 2'd2;
    xfer("t4_w0", 1'b1, 2'b10, 32'h40, 32'hA0A0_A0A0, 0, 5, 32'h0);
    xfer("t4_w1", 1'b1, 2'b10, 32'h44, 32'hA1A1_A1A1, 0, 5, 32'h0);
    xfer("t4_w2", 1'b1, 2'b10, 32'h48, 32'hA2A2_A2A2, 0, 5, 32'h0);
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h40;
    @(negedge clk);
    check("t4_r1_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    addr = 32'h44;
    @(negedge clk);
    check("t4_r2_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    addr = 32'h48;
    acc3 = -1; nd = 0;
    for (int cyc = 3; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (req && addr_ok && acc3 < 0) acc3 = cyc;
      if (data_ok) begin
        if (nd < 3) begin
          dcyc[nd] = cyc;
          ddat[nd] = rdata;
        end
        nd++;
      end
      @(posedge clk); #1;
      if (acc3 >= 0) req = 1'b0;
    end
    check("t4_r3_accept_cycle", acc3, 7);
    check("t4_dok_count", nd, 3);
    check("t4_dok0_cycle", dcyc[0], 6);
    check("t4_dok1_cycle", dcyc[1], 7);
    check("t4_dok2_cycle", dcyc[2], 12);
    check("t4_dok0_rdata", ddat[0], 32'hA0A0_A0A0);
    check("t4_dok1_rdata", ddat[1], 32'hA1A1_A1A1);
    check("t4_dok2_rdata", ddat[2], 32'hA2A2_A2A2);

    // Test 6: reset with two reads in flight drops them; RAM survives.
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h40;
    @(negedge clk);
    check("t6_r1_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    addr = 32'h44;
    @(negedge clk);
    check("t6_r2_aok", addr_ok, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ndok = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_ok) ndok++;
      @(posedge clk); #1;
    end
    check("t6_no_dok_after_rst", ndok, 0);
    xfer("t6_rd", 1'b0, 2'b10, 32'h48, 32'h0, 0, 5, 32'hA2A2_A2A2);
    sel = 2'd0;
    xfer("t6_rd_a", 1'b0, 2'b10, 32'h10, 32'h0, 0, 1, 32'h99AB_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
